// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART message transmitter.
// Holds the message FSM state enum, mode constants and the baud divider.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LOAD,
    ST_SEND,
    ST_NEXT,
    ST_DONE
  } msg_state_t;

  localparam int MODE_PERIODIC  = 0;
  localparam int MODE_TRIGGERED = 1;

  function automatic int div_calc(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Single-byte UART serializer: start bit, 8 data bits LSB first, stop bits.
// Each bit is held for DIV clock cycles.
module uart_tx_core #(
  parameter int DIV       = 434,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int             BW   = $clog2(DIV);
  localparam logic [BW-1:0]  BMAX = BW'(DIV - 1);
  localparam logic [3:0]     LAST = 4'(8 + STOP_BITS);

  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tick;
  logic          last;

  assign tick = (baud_q == BMAX);
  assign last = tick && (bit_q == LAST);

  always_comb begin
    busy_d = busy_q;
    tx_d   = tx_q;
    baud_d = baud_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    if (load && !busy_q) begin
      busy_d = 1'b1;
      tx_d   = 1'b0;
      baud_d = '0;
      bit_d  = '0;
      sh_d   = data;
    end else if (busy_q) begin
      if (!tick) begin
        baud_d = baud_q + 1'b1;
      end else begin
        baud_d = '0;
        if (bit_q == LAST) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
          bit_d  = '0;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            tx_d = sh_q[0];
            sh_d = {1'b1, sh_q[7:1]};
          end else begin
            tx_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
    end else begin
      busy_q <= busy_d;
      tx_q   <= tx_d;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
    end
  end

  // Busy drops in the final stop-bit cycle so the caller can queue the next byte.
  assign tx   = tx_q;
  assign busy = busy_q & ~last;

endmodule

// File: rtl/uart_msg_tx.sv
// Fixed-string UART message transmitter, periodic banner or triggered.
// Sequences MSG bytes (byte 0 first) through uart_tx_core.
module uart_msg_tx
  import uart_pkg::*;
#(
  parameter int                 CLK_HZ        = 50_000_000,
  parameter int                 BAUD          = 115_200,
  parameter int                 STOP_BITS     = 1,
  parameter int                 MSG_LEN       = 7,
  parameter logic [MSG_LEN*8-1:0] MSG         = 56'h0a_0d_6f_6c_6c_65_48,
  parameter int                 MODE          = 0,
  parameter int                 PERIOD_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  output logic       uart_tx,
  output logic       busy,
  output logic       done,
  output logic [7:0] byte_idx
);

  localparam int  DIV      = div_calc(CLK_HZ, BAUD);
  localparam bit  PERIODIC = (MODE == MODE_PERIODIC);

  if (DIV < 2) begin : g_bad_div
    $error("uart_msg_tx: CLK_HZ/BAUD must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_msg_tx: STOP_BITS must be 1 or 2");
  end
  if (MSG_LEN < 1 || MSG_LEN > 255) begin : g_bad_len
    $error("uart_msg_tx: MSG_LEN must be 1..255");
  end

  msg_state_t  state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        load;
  logic        core_busy;
  logic [7:0]  cur_byte;

  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx_q == 8'(i)) cur_byte = MSG[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (en && PERIODIC)        state_d = ST_WAIT;
        else if (en && start)      state_d = ST_LOAD;
      end
      ST_WAIT: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 32'(PERIOD_CYCLES - 1)) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!core_busy) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (idx_q < 8'(MSG_LEN - 1)) begin
          idx_d   = idx_q + 8'd1;
          state_d = ST_LOAD;
        end else begin
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = (PERIODIC && en) ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  uart_tx_core #(
    .DIV       (DIV),
    .STOP_BITS (STOP_BITS)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (cur_byte),
    .tx   (uart_tx),
    .busy (core_busy)
  );

  assign busy     = (state_q == ST_LOAD) || (state_q == ST_SEND) ||
                    (state_q == ST_NEXT);
  assign done     = (state_q == ST_DONE);
  assign byte_idx = idx_q;

endmodule
